// File: rtl/fetch_controller.sv
// -----------------------------------------------------------------------------
// fetch_controller
//   Instruction-fetch front end.  Holds the program counter, presents it to a
//   combinational instruction memory, and registers the returned word for the
//   decode stage.  Supports start, branch redirect, decode stall, end-of-memory
//   detection and address faults.
//
// Parameters
//   MEM_BYTES : instruction memory size in bytes; legal words 0..MEM_BYTES-4
//   RESET_PC  : PC value loaded by reset
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   asynchronous active-low reset
//   Start          in   pulse: begin fetching at Start_Address
//   Start_Address  in   64-bit first fetch address
//   Branch_Taken   in   redirect request from execute
//   Branch_Target  in   64-bit redirect address
//   Stall          in   decode not ready
//   Inst_Address   out  64-bit address to instruction memory (== PC)
//   Instruction    in   32-bit combinational read data
//   IF_Valid       out  IF_Instruction / IF_PC hold a valid word
//   IF_Instruction out  registered fetched instruction
//   IF_PC          out  address IF_Instruction came from
//   Done           out  fetch ran past the last legal word
//   Fault          out  illegal start or branch address seen
//   Fetch_Count    out  instructions delivered since last Start (saturating)
// -----------------------------------------------------------------------------
module fetch_controller #(
  parameter int          MEM_BYTES = 80,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [63:0] Start_Address,
  input  logic        Branch_Taken,
  input  logic [63:0] Branch_Target,
  input  logic        Stall,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic        IF_Valid,
  output logic [31:0] IF_Instruction,
  output logic [63:0] IF_PC,
  output logic        Done,
  output logic        Fault,
  output logic [31:0] Fetch_Count
);

  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic        r_if_valid;
  logic [31:0] r_if_inst;
  logic [63:0] r_if_pc;
  logic [31:0] r_fetch_count;

  state_t      w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic        w_if_valid_nxt;
  logic [31:0] w_if_inst_nxt;
  logic [63:0] w_if_pc_nxt;
  logic [31:0] w_fetch_count_nxt;
  logic [63:0] w_pc_plus4;

  // A fetch address is legal when word-aligned and inside the memory.
  function automatic logic addr_legal(input logic [63:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_ADDR);
  endfunction

  assign w_pc_plus4 = r_pc + 64'd4;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_inst     <= 32'd0;
      r_if_pc       <= 64'd0;
      r_fetch_count <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_if_valid    <= w_if_valid_nxt;
      r_if_inst     <= w_if_inst_nxt;
      r_if_pc       <= w_if_pc_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  // Next-state and datapath update; everything holds unless an event fires.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_if_valid_nxt    = r_if_valid;
    w_if_inst_nxt     = r_if_inst;
    w_if_pc_nxt       = r_if_pc;
    w_fetch_count_nxt = r_fetch_count;

    case (r_state)
      ST_RUN: begin
        if (Branch_Taken) begin
          // Flush the fetched word; redirect or fault on a bad target.
          w_if_valid_nxt = 1'b0;
          if (addr_legal(Branch_Target)) begin
            w_pc_nxt = Branch_Target;
          end else begin
            w_state_nxt = ST_FAULT;
          end
        end else if (Stall && r_if_valid) begin
          // Decode is holding the current word; freeze the pipeline.
          w_pc_nxt = r_pc;
        end else begin
          w_if_inst_nxt  = Instruction;
          w_if_pc_nxt    = r_pc;
          w_if_valid_nxt = 1'b1;
          if (r_fetch_count != 32'hFFFF_FFFF) begin
            w_fetch_count_nxt = r_fetch_count + 32'd1;
          end else begin
            w_fetch_count_nxt = r_fetch_count;
          end
          // Last word captured: stop with PC parked on it.
          if (w_pc_plus4 > LAST_ADDR) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_pc_nxt = w_pc_plus4;
          end
        end
      end

      ST_IDLE, ST_DONE, ST_FAULT: begin
        // In DONE the final word drains once decode accepts it.
        if ((r_state == ST_DONE) && !Stall) begin
          w_if_valid_nxt = 1'b0;
        end else begin
          w_if_valid_nxt = r_if_valid;
        end
        if (Start) begin
          if (addr_legal(Start_Address)) begin
            w_pc_nxt          = Start_Address;
            w_fetch_count_nxt = 32'd0;
            w_state_nxt       = ST_RUN;
          end else begin
            w_state_nxt    = ST_FAULT;
            w_if_valid_nxt = 1'b0;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_if_valid_nxt = 1'b0;
      end
    endcase
  end

  assign Inst_Address   = r_pc;
  assign IF_Valid       = r_if_valid;
  assign IF_Instruction = r_if_inst;
  assign IF_PC          = r_if_pc;
  assign Fetch_Count    = r_fetch_count;
  assign Done           = (r_state == ST_DONE);
  assign Fault          = (r_state == ST_FAULT);

endmodule
